seg_scan: RTL and testbench

Four-digit multiplexed seven-segment display driver for the stopwatch. It sits directly downstream of the cascaded decade counters and consumes their 4-bit BCD `value` outputs. It time-multiplexes one digit at a time onto shared active-low segment lines. A frame-synchronous shadow register prevents tearing, and a hold input freezes the displayed time for lap display.

---
 rtl/seg_scan.sv | 104 ++++++++++
 tb/tb_seg_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed seven-segment driver with frame-synchronous
// shadow registers and a hold input for lap display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seg_scan #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIV_WIDTH   = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_mask,
  input  logic       hold,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [DIV_WIDTH-1:0] TC_VAL = DIV_WIDTH'(REFRESH_DIV - 1);

  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [1:0]           idx_q, idx_d;
  logic [3:0][3:0]      sh_q, sh_d;
  logic [3:0]           sh_dp_q, sh_dp_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 tc_c;
  logic                 blank_c;
  logic [3:0]           cur_c;

  // BCD to active-low {g,f,e,d,c,b,a}; illegal codes show blank
  function automatic logic [6:0] decode7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Prescaler, digit index and frame-boundary shadow load
  always_comb begin
    tc_c    = (presc_q == TC_VAL);
    presc_d = tc_c ? '0 : presc_q + DIV_WIDTH'(1);
    idx_d   = tc_c ? idx_q + 2'd1 : idx_q;
    sh_d    = sh_q;
    sh_dp_d = sh_dp_q;
    if (tc_c && (idx_q == 2'd3) && !hold) begin
      sh_d    = {d3, d2, d1, d0};
      sh_dp_d = dp_mask;
    end
  end

  // Output pattern for the digit currently selected by idx
  always_comb begin
    cur_c   = sh_q[idx_q];
    blank_c = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every digit above it is zero; digit 0 always shows
    blank_c = (idx_q != 2'd0) && ((16'(sh_q) >> {idx_q, 2'b00}) == 16'd0);
`endif
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank_c ? 7'h7F : decode7(cur_c);
    dp_d  = ~sh_dp_q[idx_q];
  end

  // Registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
      sh_q    <= '0;
      sh_dp_q <= 4'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      sh_dp_q <= sh_dp_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan.sv
// Testbench for seg_scan: reference scan model feeds a scoreboard queue of
// expected {an,seg,dp} per edge, compared one cycle later against the DUT.
module tb_seg_scan;

  localparam int unsigned RD = 4;
  localparam int unsigned FRAME = 4 * RD;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] din [4];
  logic [3:0] dp_mask;
  logic       hold;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int vectors;
  int miscompares;

  // Reference state: edges since reset release and the displayed shadow
  int         m_edge;
  logic [3:0] m_sh [4];
  logic [3:0] m_dp;
  exp_t       sb_q [$];

  seg_scan #(.REFRESH_DIV(RD), .DIV_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .d0(din[0]), .d1(din[1]), .d2(din[2]), .d3(din[3]),
    .dp_mask(dp_mask), .hold(hold),
    .an(an), .seg(seg), .dp(dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected output after the next edge, then advance the reference
  function automatic exp_t predict();
    exp_t e;
    int   dig;
    logic blank;
    dig   = (m_edge / RD) % 4;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (dig > 0);
    for (int j = dig; j < 4; j++) if (m_sh[j] != 4'd0) blank = 1'b0;
`endif
    e.an  = ~(4'b0001 << dig);
    e.seg = blank ? 7'h7F : ref_seg(m_sh[dig]);
    e.dp  = ~m_dp[dig];
    if ((m_edge % FRAME) == FRAME - 1 && !hold) begin
      for (int j = 0; j < 4; j++) m_sh[j] = din[j];
      m_dp = dp_mask;
    end
    m_edge++;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive n edges, pushing expectations and popping them as outputs appear
  task automatic run(input int n, input string tag);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      sb_q.push_back(predict());
      step();
      e = sb_q.pop_front();
      vectors++;
      if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
        miscompares++;
        $display("FAIL %s edge=%0d got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 tag, m_edge - 1, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  endtask

  // One reset edge, check reset outputs, release and clear the reference
  task automatic do_reset(input string tag);
    rst = 1'b1;
    step();
    vectors++;
    if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
      miscompares++;
      $display("FAIL %s_rst got an=%b seg=%h dp=%b want an=1111 seg=7f dp=1",
               tag, an, seg, dp);
    end
    rst    = 1'b0;
    m_edge = 0;
    for (int j = 0; j < 4; j++) m_sh[j] = 4'd0;
    m_dp = 4'd0;
  endtask

  task automatic set_digits(input logic [3:0] v3, input logic [3:0] v2,
                            input logic [3:0] v1, input logic [3:0] v0);
    din[3] = v3; din[2] = v2; din[1] = v1; din[0] = v0;
  endtask

  task automatic test_reset();
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    dp_mask = 4'b1111;
    hold    = 1'b0;
    rst     = 1'b1;
    step();
    do_reset("reset");
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    dp_mask = 4'd0;
    run(FRAME, "reset_scan");
  endtask

  task automatic test_digits();
    do_reset("digits");
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    dp_mask = 4'd0;
    run(2 * FRAME, "digits");
  endtask

  task automatic test_hold();
    do_reset("hold");
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    run(FRAME, "hold_load");
    hold = 1'b1;
    set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    run(3 * FRAME, "hold_frozen");
    hold = 1'b0;
    run(2 * FRAME, "hold_release");
  endtask

  task automatic test_illegal_dp();
    do_reset("illegal");
    set_digits(4'd3, 4'd12, 4'd8, 4'd6);
    dp_mask = 4'b0100;
    run(2 * FRAME, "illegal_dp");
  endtask

  task automatic test_midscan_reset();
    do_reset("mid");
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    dp_mask = 4'b1010;
    run(FRAME + 2 * RD + 1, "mid_pre");
    do_reset("mid_scan");
    run(FRAME + RD, "mid_restart");
  endtask

  task automatic test_leading_zero();
    do_reset("lzb");
    set_digits(4'd0, 4'd0, 4'd7, 4'd0);
    dp_mask = 4'd0;
    run(2 * FRAME, "lzb");
  endtask

  // Random digits, masks and hold toggled at arbitrary cycles, incl. boundaries
  task automatic test_back_to_back();
    do_reset("b2b");
    for (int k = 0; k < 6 * FRAME; k++) begin
      if ($urandom_range(0, 3) == 0)
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) dp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) hold = ~hold;
      run(1, "b2b");
    end
    hold = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    hold        = 1'b0;
    dp_mask     = 4'd0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    m_edge = 0;
    m_dp   = 4'd0;
    for (int j = 0; j < 4; j++) m_sh[j] = 4'd0;

    test_reset();
    test_digits();
    test_hold();
    test_illegal_dp();
    test_midscan_reset();
    test_leading_zero();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
